// File: rtl/eth_rx_fcs_check_if.sv
// Receive byte stream in, stripped payload and per-frame FCS/length status out.
// The master side drives the GMII-style receive signals; the slave side is the checker.
interface eth_rx_fcs_check_if;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rx_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        frame_done;
  logic        fcs_ok;
  logic        frame_ok;
  logic [15:0] frame_len;

  modport master (
    output rx_dv, rx_er, rx_data,
    input  out_valid, out_data, out_sof, out_eof,
    input  frame_done, fcs_ok, frame_ok, frame_len
  );

  modport slave (
    input  rx_dv, rx_er, rx_data,
    output out_valid, out_data, out_sof, out_eof,
    output frame_done, fcs_ok, frame_ok, frame_len
  );
endinterface

// File: rtl/eth_rx_fcs_check.sv
// Ethernet receive FCS checker: strips preamble/SFD, checks CRC32 over DA..FCS,
// forwards payload without the trailing 4 FCS bytes and reports frame status.
module eth_rx_fcs_check #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic               clk,
  input  logic               rst_n,
  eth_rx_fcs_check_if.slave  rx_if
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_t;

  localparam logic [31:0] LP_POLY    = 32'h04C11DB7;
  localparam logic [31:0] LP_RESIDUE = 32'hC704DD7B;
  localparam logic [15:0] LP_MIN     = 16'(MIN_LEN);
  localparam logic [15:0] LP_MAX     = 16'(MAX_LEN);
  localparam logic [7:0]  LP_PRE     = 8'h55;
  localparam logic [7:0]  LP_SFD     = 8'hD5;

  state_t      r_state;
  state_t      w_next;

  logic        w_dv;
  logic        w_er;
  logic [7:0]  w_data;

  logic        w_enter;
  logic        w_take;
  logic        w_end;
  logic        w_full;
  logic        w_emit;
  logic        w_fcs_match;
  logic        w_len_ok;

  logic [31:0] r_crc;
  logic [15:0] r_cnt;
  logic        r_err;
  logic [2:0]  r_occ;
  logic        r_first;
  logic [39:0] r_dl;

  logic        r_out_valid;
  logic [7:0]  r_out_data;
  logic        r_out_sof;
  logic        r_out_eof;
  logic        r_frame_done;
  logic        r_fcs_ok;
  logic        r_frame_ok;
  logic [15:0] r_frame_len;

  assign w_dv   = rx_if.rx_dv;
  assign w_er   = rx_if.rx_er;
  assign w_data = rx_if.rx_data;

  function automatic logic [7:0] f_rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) begin
      r[i] = d[3'(7 - i)];
    end
    return r;
  endfunction

  // MSB-first shift register fed with the bit-reversed byte, i.e. line order.
  function automatic logic [31:0] f_crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] n;
    logic        fb;
    n = c;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = n[31] ^ b[3'(7 - i)];
      n  = {n[30:0], 1'b0};
      if (fb) begin
        n = n ^ LP_POLY;
      end
    end
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_dv) begin
          w_next = (w_data == LP_PRE) ? S_PREAMBLE : S_DROP;
        end
      end
      S_PREAMBLE: begin
        if (!w_dv) begin
          w_next = S_IDLE;
        end else if (w_data == LP_SFD) begin
          w_next = S_DATA;
        end else if (w_data != LP_PRE) begin
          w_next = S_DROP;
        end
      end
      S_DATA: begin
        if (!w_dv) begin
          w_next = S_IDLE;
        end
      end
      S_DROP: begin
        if (!w_dv) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_enter     = (r_state == S_PREAMBLE) && w_dv && (w_data == LP_SFD);
    w_take      = (r_state == S_DATA) && w_dv;
    w_end       = (r_state == S_DATA) && !w_dv;
    w_full      = (r_occ == 3'd5);
    w_emit      = (w_take || w_end) && w_full;
    // A frame too short to hold an FCS can never report a good FCS.
    w_fcs_match = w_full && (r_crc == LP_RESIDUE);
    w_len_ok    = (r_cnt >= LP_MIN) && (r_cnt <= LP_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc   <= '1;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_occ   <= '0;
      r_first <= 1'b0;
      r_dl    <= '0;
    end else begin
      r_crc <= w_take ? f_crc_byte(r_crc, f_rev8(w_data)) : '1;
      if (w_enter) begin
        r_cnt   <= '0;
        r_err   <= 1'b0;
        r_occ   <= '0;
        r_first <= 1'b1;
      end else begin
        if (w_take && (r_cnt != '1)) begin
          r_cnt <= r_cnt + 16'd1;
        end
        if (w_take && w_er) begin
          r_err <= 1'b1;
        end
        if (w_take && !w_full) begin
          r_occ <= r_occ + 3'd1;
        end
        if (w_emit) begin
          r_first <= 1'b0;
        end
      end
      if (w_take) begin
        r_dl <= {r_dl[31:0], w_data};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sof    <= 1'b0;
      r_out_eof    <= 1'b0;
      r_frame_done <= 1'b0;
      r_fcs_ok     <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_frame_len  <= '0;
    end else begin
      r_out_valid  <= w_emit;
      r_out_sof    <= w_emit && r_first;
      r_out_eof    <= w_end && w_full;
      r_frame_done <= w_end;
      if (w_emit) begin
        r_out_data <= r_dl[39:32];
      end
      if (w_end) begin
        r_fcs_ok    <= w_fcs_match;
        r_frame_ok  <= w_fcs_match && !r_err && w_len_ok;
        r_frame_len <= r_cnt;
      end
    end
  end

  assign rx_if.out_valid  = r_out_valid;
  assign rx_if.out_data   = r_out_data;
  assign rx_if.out_sof    = r_out_sof;
  assign rx_if.out_eof    = r_out_eof;
  assign rx_if.frame_done = r_frame_done;
  assign rx_if.fcs_ok     = r_fcs_ok;
  assign rx_if.frame_ok   = r_frame_ok;
  assign rx_if.frame_len  = r_frame_len;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: frames built in a queue, FCS from a
// reflected CRC32 reference, DUT outputs captured on the falling edge.
module tb_eth_rx_fcs_check;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  eth_rx_fcs_check_if rx_if ();

  eth_rx_fcs_check #(
    .MIN_LEN(64),
    .MAX_LEN(1518)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (rx_if)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] tx[$];
  logic [7:0] q_d[$];
  bit         q_sof[$];
  bit         q_eof[$];
  int         q_cyc[$];
  int         n_done = 0;
  int         done_cyc = 0;
  logic       d_fcs;
  logic       d_ok;
  logic [15:0] d_len;
  int         first_cyc;
  int         drop_cyc;

  always @(negedge clk) begin
    cyc++;
    if (rx_if.out_valid === 1'b1) begin
      q_d.push_back(rx_if.out_data);
      q_sof.push_back(rx_if.out_sof);
      q_eof.push_back(rx_if.out_eof);
      q_cyc.push_back(cyc);
    end
    if (rx_if.frame_done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
      d_fcs = rx_if.fcs_ok;
      d_ok  = rx_if.frame_ok;
      d_len = rx_if.frame_len;
    end
  end

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(posedge clk);
    #2;
    rx_if.rx_dv   = dv;
    rx_if.rx_er   = er;
    rx_if.rx_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic add_fcs();
    logic [31:0] c;
    c = '1;
    foreach (tx[i]) begin
      c = c ^ {24'h0, tx[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    tx.push_back(c[7:0]);
    tx.push_back(c[15:8]);
    tx.push_back(c[23:16]);
    tx.push_back(c[31:24]);
  endtask

  task automatic build(input int n_payload);
    tx.delete();
    for (int i = 0; i < n_payload; i++) tx.push_back(8'(i));
    add_fcs();
  endtask

  task automatic send(input int npre, input int er_idx);
    for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < tx.size(); i++) begin
      drive(1'b1, (i == er_idx), tx[i]);
      if (i == 0) first_cyc = cyc;
    end
    drive(1'b0, 1'b0, 8'h00);
    drop_cyc = cyc;
  endtask

  task automatic test_reset();
    logic [30:0] v;
    rx_if.rx_dv = 1'b0;
    rx_if.rx_er = 1'b0;
    rx_if.rx_data = 8'h00;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    v = {rx_if.out_valid, rx_if.out_data, rx_if.out_sof, rx_if.out_eof, rx_if.frame_done,
         rx_if.fcs_ok, rx_if.frame_ok, rx_if.frame_len};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", v); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(3);
    checks++;
    if (n_done !== 0 || q_d.size() !== 0) begin
      errors++; $display("FAIL reset_quiet: got done=%0d bytes=%0d expected 0/0", n_done, q_d.size());
    end
  endtask

  task automatic test_min_frame();
    int bq, bd, nsof, neof;
    build(60);
    bq = q_d.size(); bd = n_done;
    send(7, -1);
    idle(3);
    checks++;
    if (q_d.size() - bq !== 60) begin errors++; $display("FAIL min_count: got %0d expected 60", q_d.size() - bq); end
    nsof = 0; neof = 0;
    for (int i = 0; i < 60 && bq + i < q_d.size(); i++) begin
      checks++;
      if (q_d[bq+i] !== 8'(i)) begin errors++; $display("FAIL min_byte%0d: got %h expected %h", i, q_d[bq+i], 8'(i)); end
      nsof += q_sof[bq+i]; neof += q_eof[bq+i];
    end
    checks++;
    if (q_sof[bq] !== 1'b1 || nsof !== 1) begin errors++; $display("FAIL min_sof: got first=%0d total=%0d expected 1/1", q_sof[bq], nsof); end
    checks++;
    if (q_eof[bq+59] !== 1'b1 || neof !== 1) begin errors++; $display("FAIL min_eof: got last=%0d total=%0d expected 1/1", q_eof[bq+59], neof); end
    checks++;
    if (q_cyc[bq] !== first_cyc + 7) begin errors++; $display("FAIL min_latency: got cycle %0d expected %0d", q_cyc[bq], first_cyc + 7); end
    checks++;
    if (n_done - bd !== 1 || done_cyc !== drop_cyc + 2) begin
      errors++; $display("FAIL min_done: got n=%0d cyc=%0d expected 1 at %0d", n_done - bd, done_cyc, drop_cyc + 2);
    end
    checks++;
    if (q_cyc[bq+59] !== done_cyc) begin errors++; $display("FAIL min_eof_cycle: got %0d expected %0d", q_cyc[bq+59], done_cyc); end
    checks++;
    if ({d_fcs, d_ok, d_len} !== {1'b1, 1'b1, 16'd64}) begin
      errors++; $display("FAIL min_status: got fcs=%0d ok=%0d len=%0d expected 1 1 64", d_fcs, d_ok, d_len);
    end
  endtask

  task automatic test_crc_vector();
    int bq, bd;
    tx = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    bq = q_d.size(); bd = n_done;
    send(1, -1);
    idle(3);
    checks++;
    if (q_d.size() - bq !== 9) begin errors++; $display("FAIL vec_count: got %0d expected 9", q_d.size() - bq); end
    for (int i = 0; i < 9 && bq + i < q_d.size(); i++) begin
      checks++;
      if (q_d[bq+i] !== 8'h31 + 8'(i)) begin errors++; $display("FAIL vec_byte%0d: got %h expected %h", i, q_d[bq+i], 8'h31 + 8'(i)); end
    end
    checks++;
    if (q_eof[bq+8] !== 1'b1 || q_sof[bq] !== 1'b1) begin errors++; $display("FAIL vec_marks: got sof=%0d eof=%0d expected 1/1", q_sof[bq], q_eof[bq+8]); end
    checks++;
    if (n_done - bd !== 1 || {d_fcs, d_ok, d_len} !== {1'b1, 1'b0, 16'd13}) begin
      errors++; $display("FAIL vec_status: got n=%0d fcs=%0d ok=%0d len=%0d expected 1 1 0 13", n_done - bd, d_fcs, d_ok, d_len);
    end
  endtask

  task automatic test_corrupt();
    int bq;
    build(60);
    tx[10] = tx[10] ^ 8'h01;
    bq = q_d.size();
    send(7, -1);
    idle(3);
    checks++;
    if (q_d.size() - bq !== 60) begin errors++; $display("FAIL bad_count: got %0d expected 60", q_d.size() - bq); end
    for (int i = 0; i < 60 && bq + i < q_d.size(); i++) begin
      checks++;
      if (q_d[bq+i] !== tx[i]) begin errors++; $display("FAIL bad_byte%0d: got %h expected %h", i, q_d[bq+i], tx[i]); end
    end
    checks++;
    if ({d_fcs, d_ok, d_len} !== {1'b0, 1'b0, 16'd64}) begin
      errors++; $display("FAIL bad_status: got fcs=%0d ok=%0d len=%0d expected 0 0 64", d_fcs, d_ok, d_len);
    end
  endtask

  task automatic test_rx_er();
    int bd;
    build(60);
    bd = n_done;
    send(7, 30);
    idle(3);
    checks++;
    if (n_done - bd !== 1 || {d_fcs, d_ok, d_len} !== {1'b1, 1'b0, 16'd64}) begin
      errors++; $display("FAIL rxer_status: got n=%0d fcs=%0d ok=%0d len=%0d expected 1 1 0 64", n_done - bd, d_fcs, d_ok, d_len);
    end
  endtask

  task automatic test_bad_preamble();
    int bq, bd, mq, md;
    bq = q_d.size(); bd = n_done;
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h54);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b0, 1'b0, 8'h00);
    mq = q_d.size(); md = n_done;
    build(60);
    send(7, -1);
    idle(3);
    checks++;
    if (mq !== bq || md !== bd) begin errors++; $display("FAIL drop_quiet: got bytes=%0d done=%0d expected 0/0", mq - bq, md - bd); end
    checks++;
    if (q_d.size() - mq !== 60 || n_done - md !== 1 || d_ok !== 1'b1) begin
      errors++; $display("FAIL drop_next: got bytes=%0d done=%0d ok=%0d expected 60 1 1", q_d.size() - mq, n_done - md, d_ok);
    end
  endtask

  task automatic test_reset_mid();
    int bq, bd;
    logic [30:0] v;
    build(60);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, tx[i]);
    drive(1'b1, 1'b0, tx[30]);
    rst_n = 1'b0;
    bq = q_d.size(); bd = n_done;
    @(negedge clk);
    v = {rx_if.out_valid, rx_if.out_data, rx_if.out_sof, rx_if.out_eof, rx_if.frame_done,
         rx_if.fcs_ok, rx_if.frame_ok, rx_if.frame_len};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL midrst_outputs: got %h expected 0", v); end
    drive(1'b1, 1'b0, tx[31]);
    drive(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    idle(3);
    checks++;
    if (n_done !== bd || q_d.size() !== bq) begin
      errors++; $display("FAIL midrst_abort: got done=%0d bytes=%0d expected 0/0", n_done - bd, q_d.size() - bq);
    end
    tx = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send(1, -1);
    idle(3);
    checks++;
    if (n_done - bd !== 1 || {d_fcs, d_ok, d_len} !== {1'b0, 1'b0, 16'd4}) begin
      errors++; $display("FAIL short_status: got n=%0d fcs=%0d ok=%0d len=%0d expected 1 0 0 4", n_done - bd, d_fcs, d_ok, d_len);
    end
    checks++;
    if (q_d.size() !== bq) begin errors++; $display("FAIL short_payload: got %0d bytes expected 0", q_d.size() - bq); end
  endtask

  task automatic test_back_to_back();
    int bq, bd;
    bq = q_d.size(); bd = n_done;
    tx = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    send(1, -1);
    build(60);
    send(7, -1);
    idle(3);
    checks++;
    if (q_d.size() - bq !== 69 || n_done - bd !== 2) begin
      errors++; $display("FAIL b2b_counts: got bytes=%0d done=%0d expected 69 2", q_d.size() - bq, n_done - bd);
    end
    checks++;
    if (q_eof[bq+8] !== 1'b1 || q_sof[bq+9] !== 1'b1 || q_d[bq+9] !== 8'h00) begin
      errors++; $display("FAIL b2b_boundary: got eof=%0d sof=%0d data=%h expected 1 1 00", q_eof[bq+8], q_sof[bq+9], q_d[bq+9]);
    end
    checks++;
    if ({d_fcs, d_ok, d_len} !== {1'b1, 1'b1, 16'd64}) begin
      errors++; $display("FAIL b2b_status: got fcs=%0d ok=%0d len=%0d expected 1 1 64", d_fcs, d_ok, d_len);
    end
  endtask

  task automatic test_len_bounds();
    int  lens[3] = '{63, 1518, 1519};
    bit  exp_ok[3] = '{1'b0, 1'b1, 1'b0};
    for (int t = 0; t < 3; t++) begin
      build(lens[t] - 4);
      send(1, -1);
      idle(2);
      checks++;
      if ({d_fcs, d_ok, d_len} !== {1'b1, exp_ok[t], 16'(lens[t])}) begin
        errors++; $display("FAIL len%0d_status: got fcs=%0d ok=%0d len=%0d expected 1 %0d %0d",
                           lens[t], d_fcs, d_ok, d_len, exp_ok[t], lens[t]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_min_frame();
    test_crc_vector();
    test_corrupt();
    test_rx_er();
    test_bad_preamble();
    test_reset_mid();
    test_back_to_back();
    test_len_bounds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
